// File: rtl/ahb_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_arbiter
//
// Shares one AHB-Lite slave fabric between up to eight bus masters (the
// debug-UART AHB master plus DMA/test masters). Round-robin priority with a
// burst-boundary-aware handover, locked-transfer hold and a default master
// that owns the bus whenever nobody is asking for it.
//
// Parameters:
//   NUM_MST   number of masters (2..8)
//   DEF_MST   default master index, granted after reset and when idle
//
// Ports:
//   HCLK       in   1        clock
//   HRST_N     in   1        asynchronous active-low reset
//   HBUSREQ    in   NUM_MST  per-master bus request
//   HLOCK      in   NUM_MST  per-master locked-transfer request
//   HTRANS     in   2        transfer type of the current bus owner
//   HBURST     in   3        burst type of the current bus owner
//   HREADY     in   1        slave ready
//   HRESP      in   2        slave response
//   HGRANT     out  NUM_MST  one-hot grant
//   HMASTER    out  3        index of the master owning the address phase
//   HMASTLOCK  out  1        current address phase is locked
// ---------------------------------------------------------------------------
module ahb_arbiter #(
    parameter int NUM_MST = 4,
    parameter int DEF_MST = 0
) (
    input  logic               HCLK,
    input  logic               HRST_N,
    input  logic [NUM_MST-1:0] HBUSREQ,
    input  logic [NUM_MST-1:0] HLOCK,
    input  logic [1:0]         HTRANS,
    input  logic [2:0]         HBURST,
    input  logic               HREADY,
    input  logic [1:0]         HRESP,
    output logic [NUM_MST-1:0] HGRANT,
    output logic [2:0]         HMASTER,
    output logic               HMASTLOCK
);

    localparam logic [1:0] TRANS_IDLE   = 2'd0;
    localparam logic [1:0] TRANS_NONSEQ = 2'd2;
    localparam logic [1:0] TRANS_SEQ    = 2'd3;

    localparam logic [2:0] BURST_SINGLE = 3'd0;
    localparam logic [2:0] BURST_INCR   = 3'd1;

    localparam logic [1:0] RESP_OKAY    = 2'd0;
    localparam logic [1:0] RESP_ERROR   = 2'd1;

    localparam logic [2:0] DEF_IDX      = 3'(DEF_MST);

    logic [2:0] grant_idx;
    logic [2:0] rr_ptr;
    logic [2:0] next_grant;
    logic [2:0] scan_idx;
    logic [3:0] beat_cnt;
    logic [3:0] beat_cnt_next;
    logic [3:0] burst_load;
    logic [7:0] req8;
    logic [7:0] lock8;
    logic       grantee_lock;
    logic       at_boundary;
    logic       arb;
    logic       req_found;

    // Remaining beats after the first one of a fixed-length burst. Plain
    // INCR has no known length, so it loads zero and is always interruptible.
    always_comb begin
        burst_load = 4'd0;
        case (HBURST)
            3'b010, 3'b011: burst_load = 4'd3;
            3'b100, 3'b101: burst_load = 4'd7;
            3'b110, 3'b111: burst_load = 4'd15;
            default:        burst_load = 4'd0;
        endcase
    end

    // Beat counter: reload on NONSEQ, count down (saturating) on SEQ, hold on
    // BUSY/IDLE. An ERROR completion abandons the burst, so the count is
    // cleared; RETRY/SPLIT completions leave it untouched because the master
    // will re-issue the same beat.
    always_comb begin
        beat_cnt_next = beat_cnt;
        if (HREADY) begin
            if (HRESP == RESP_ERROR) begin
                beat_cnt_next = 4'd0;
            end else if (HRESP == RESP_OKAY) begin
                if (HTRANS == TRANS_NONSEQ) begin
                    beat_cnt_next = burst_load;
                end else if (HTRANS == TRANS_SEQ) begin
                    beat_cnt_next = (beat_cnt == 4'd0) ? 4'd0 : beat_cnt - 4'd1;
                end
            end
        end
    end

    // Arbitration point: the bus may change hands only on a completed,
    // non-locked transfer that sits on a burst boundary. A non-OKAY
    // completion never re-arbitrates; the owner keeps the bus to retry or
    // to cancel.
    always_comb begin
        req8         = 8'(HBUSREQ);
        lock8        = 8'(HLOCK);
        grantee_lock = lock8[grant_idx];
        at_boundary  = (HTRANS == TRANS_IDLE)
                    || ((HTRANS == TRANS_NONSEQ)
                        && ((HBURST == BURST_SINGLE) || (HBURST == BURST_INCR)))
                    || ((HTRANS == TRANS_SEQ) && (beat_cnt == 4'd1))
                    || (HBURST == BURST_INCR);
        arb          = HREADY && (HRESP == RESP_OKAY) && !HMASTLOCK
                    && !grantee_lock && at_boundary;
    end

    // Round-robin pick: scan upward from the pointer, skipping the current
    // grantee so it is only considered after everyone else. With no request
    // at all the bus parks on the default master.
    always_comb begin
        next_grant = DEF_IDX;
        req_found  = 1'b0;
        scan_idx   = 3'd0;
        for (int i = 1; i <= NUM_MST; i++) begin
            scan_idx = 3'((int'(rr_ptr) + i) % NUM_MST);
            if (!req_found && (scan_idx != grant_idx) && req8[scan_idx]) begin
                req_found  = 1'b1;
                next_grant = scan_idx;
            end
        end
        if (!req_found && req8[grant_idx]) begin
            req_found  = 1'b1;
            next_grant = grant_idx;
        end
    end

    // Grant, pointer and address-phase ownership registers. The pointer only
    // follows real requesters so parking on the default master does not
    // disturb the rotation. HMASTER/HMASTLOCK advance only when the slave
    // accepts the current transfer.
    always_ff @(posedge HCLK or negedge HRST_N) begin
        if (!HRST_N) begin
            grant_idx <= DEF_IDX;
            rr_ptr    <= DEF_IDX;
            beat_cnt  <= 4'd0;
            HMASTER   <= DEF_IDX;
            HMASTLOCK <= 1'b0;
        end else begin
            beat_cnt <= beat_cnt_next;
            if (arb) begin
                grant_idx <= next_grant;
                if (req_found) begin
                    rr_ptr <= next_grant;
                end
            end
            if (HREADY) begin
                HMASTER   <= grant_idx;
                HMASTLOCK <= lock8[grant_idx];
            end
        end
    end

    // One-hot grant decoded straight from the registered grant index.
    always_comb begin
        HGRANT = NUM_MST'(1) << grant_idx;
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_arbiter
//
// Self-checking bench for ahb_arbiter (4 masters, default master 0).
// Directed scenarios walk through idle parking, round-robin, fixed bursts
// with wait states, locked transfers, error responses and asynchronous
// reset; a randomized phase follows. Every cycle the outputs are compared
// with a transaction-level model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_ahb_arbiter;

    localparam int NUM = 4;
    localparam int DEF = 0;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] NONSEQ = 2'd2;
    localparam logic [1:0] SEQ    = 2'd3;

    localparam logic [2:0] SINGLE = 3'd0;
    localparam logic [2:0] INCR4  = 3'd3;
    localparam logic [2:0] INCR8  = 3'd5;
    localparam logic [2:0] INCR16 = 3'd7;

    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] ERROR  = 2'd1;

    logic           HCLK;
    logic           HRST_N;
    logic [NUM-1:0] HBUSREQ;
    logic [NUM-1:0] HLOCK;
    logic [1:0]     HTRANS;
    logic [2:0]     HBURST;
    logic           HREADY;
    logic [1:0]     HRESP;
    logic [NUM-1:0] HGRANT;
    logic [2:0]     HMASTER;
    logic           HMASTLOCK;

    int checks;
    int failures;

    // Reference model state: who holds the grant, who owns the address
    // phase, whether it is locked, the rotation pointer and beats left.
    int m_grant;
    int m_master;
    bit m_mlock;
    int m_ptr;
    int m_left;

    ahb_arbiter #(
        .NUM_MST (NUM),
        .DEF_MST (DEF)
    ) dut (
        .HCLK      (HCLK),
        .HRST_N    (HRST_N),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTLOCK (HMASTLOCK)
    );

    // Free-running 100 MHz clock.
    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    function automatic bit bit_of(input logic [NUM-1:0] v, input int i);
        return ((v >> i) & NUM'(1)) != '0;
    endfunction

    // Total beats in a burst type; INCR counts as a single interruptible beat.
    function automatic int burst_beats(input logic [2:0] b);
        int beats;
        if (b <= 3'd1) beats = 1;
        else           beats = 4 << ((int'(b) - 2) / 2);
        return beats;
    endfunction

    task automatic model_reset();
        m_grant  = DEF;
        m_master = DEF;
        m_mlock  = 1'b0;
        m_ptr    = DEF;
        m_left   = 0;
    endtask

    // Applies one clock edge worth of arbitration rules to the model.
    task automatic model_step();
        int  order[$];
        int  new_grant;
        bit  boundary;
        bit  may_switch;
        boundary = (HTRANS == IDLE)
                || (HTRANS == NONSEQ && burst_beats(HBURST) == 1)
                || (HTRANS == SEQ && m_left == 1)
                || (HBURST == 3'd1);
        may_switch = HREADY && (HRESP == OKAY) && !m_mlock
                  && !bit_of(HLOCK, m_grant) && boundary;
        new_grant = m_grant;
        if (may_switch) begin
            for (int k = 1; k <= NUM; k++) begin
                if ((m_ptr + k) % NUM != m_grant) order.push_back((m_ptr + k) % NUM);
            end
            order.push_back(m_grant);
            new_grant = DEF;
            foreach (order[j]) begin
                if (bit_of(HBUSREQ, order[j])) begin
                    new_grant = order[j];
                    m_ptr     = order[j];
                    break;
                end
            end
        end
        if (HREADY) begin
            m_master = m_grant;
            m_mlock  = bit_of(HLOCK, m_grant);
            if (HRESP == ERROR) begin
                m_left = 0;
            end else if (HRESP == OKAY) begin
                if (HTRANS == NONSEQ)                 m_left = burst_beats(HBURST) - 1;
                else if (HTRANS == SEQ && m_left > 0) m_left = m_left - 1;
            end
        end
        m_grant = new_grant;
    endtask

    task automatic check_output(input string tag);
        logic [NUM-1:0] exp_grant;
        exp_grant = NUM'(1) << m_grant;
        checks++;
        assert (HGRANT === exp_grant) else begin
            failures++;
            $error("[TB] FAIL %s grant: observed=%b expected=%b", tag, HGRANT, exp_grant);
        end
        checks++;
        assert (HMASTER === 3'(m_master)) else begin
            failures++;
            $error("[TB] FAIL %s master: observed=%0d expected=%0d", tag, HMASTER, m_master);
        end
        checks++;
        assert (HMASTLOCK === m_mlock) else begin
            failures++;
            $error("[TB] FAIL %s mastlock: observed=%b expected=%b", tag, HMASTLOCK, m_mlock);
        end
        checks++;
        assert ($countones(HGRANT) == 1 && int'(HMASTER) < NUM) else begin
            failures++;
            $error("[TB] FAIL %s onehot/range: observed grant=%b master=%0d expected one bit, master<%0d",
                   tag, HGRANT, HMASTER, NUM);
        end
    endtask

    task automatic check_grant(input string tag, input logic [NUM-1:0] expv);
        checks++;
        assert (HGRANT === expv) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, HGRANT, expv);
        end
    endtask

    task automatic check_master(input string tag, input logic [2:0] expv);
        checks++;
        assert (HMASTER === expv) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, HMASTER, expv);
        end
    endtask

    task automatic check_lock(input string tag, input logic expv);
        checks++;
        assert (HMASTLOCK === expv) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, HMASTLOCK, expv);
        end
    endtask

    // Drives one bus cycle, clocks it, advances the model and compares.
    task automatic apply_stimulus(input logic [NUM-1:0] req, input logic [NUM-1:0] lck,
                                  input logic [1:0] trans, input logic [2:0] burst,
                                  input logic ready, input logic [1:0] resp);
        HBUSREQ = req;
        HLOCK   = lck;
        HTRANS  = trans;
        HBURST  = burst;
        HREADY  = ready;
        HRESP   = resp;
        @(posedge HCLK);
        model_step();
        #1;
        check_output("cycle");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        HRST_N   = 1'b0;
        HBUSREQ  = '0;
        HLOCK    = '0;
        HTRANS   = IDLE;
        HBURST   = SINGLE;
        HREADY   = 1'b1;
        HRESP    = OKAY;
        model_reset();
        repeat (2) @(posedge HCLK);
        #1;
        check_output("reset");
        check_grant("reset_grant", 4'b0001);
        check_master("reset_master", 3'd0);
        check_lock("reset_lock", 1'b0);
        HRST_N = 1'b1;

        // Idle bus parks on the default master.
        repeat (3) apply_stimulus(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
        check_grant("idle_park", 4'b0001);
        check_master("idle_master", 3'd0);

        // Masters 1 and 3 request together with the pointer at 0.
        apply_stimulus(4'b1010, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
        check_grant("rr_first", 4'b0010);
        apply_stimulus(4'b1010, 4'b0000, BUSY, INCR4, 1'b1, OKAY);
        check_grant("rr_hold", 4'b0010);
        check_master("rr_handover", 3'd1);
        apply_stimulus(4'b1000, 4'b0000, NONSEQ, SINGLE, 1'b1, OKAY);
        check_grant("rr_next", 4'b1000);
        apply_stimulus(4'b1000, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
        check_master("rr_master3", 3'd3);

        // Master 2 runs INCR4 with a wait state while master 0 requests.
        apply_stimulus(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
        check_grant("burst_grant2", 4'b0100);
        apply_stimulus(4'b0101, 4'b0000, BUSY, INCR4, 1'b1, OKAY);
        check_master("burst_master2", 3'd2);
        apply_stimulus(4'b0101, 4'b0000, NONSEQ, INCR4, 1'b1, OKAY);
        apply_stimulus(4'b0001, 4'b0000, SEQ, INCR4, 1'b0, OKAY);
        check_grant("burst_wait", 4'b0100);
        apply_stimulus(4'b0001, 4'b0000, SEQ, INCR4, 1'b1, OKAY);
        apply_stimulus(4'b0001, 4'b0000, SEQ, INCR4, 1'b1, OKAY);
        check_grant("burst_beat3", 4'b0100);
        apply_stimulus(4'b0001, 4'b0000, SEQ, INCR4, 1'b1, OKAY);
        check_grant("burst_end", 4'b0001);

        // Master 1 locked transfers while master 3 requests.
        apply_stimulus(4'b1010, 4'b0010, IDLE, SINGLE, 1'b1, OKAY);
        check_grant("lock_grant", 4'b0010);
        apply_stimulus(4'b1010, 4'b0010, IDLE, SINGLE, 1'b1, OKAY);
        check_lock("lock_mastlock", 1'b1);
        apply_stimulus(4'b1010, 4'b0010, NONSEQ, SINGLE, 1'b1, OKAY);
        apply_stimulus(4'b1010, 4'b0010, NONSEQ, SINGLE, 1'b1, OKAY);
        check_grant("lock_frozen", 4'b0010);
        check_lock("lock_second", 1'b1);
        apply_stimulus(4'b1010, 4'b0000, NONSEQ, SINGLE, 1'b1, OKAY);
        check_grant("lock_tail", 4'b0010);
        check_lock("lock_dropped", 1'b0);
        apply_stimulus(4'b1000, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
        check_grant("lock_release", 4'b1000);

        // Master 2 INCR8 hits a two-cycle ERROR response.
        apply_stimulus(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
        apply_stimulus(4'b0100, 4'b0000, BUSY, INCR8, 1'b1, OKAY);
        apply_stimulus(4'b0101, 4'b0000, NONSEQ, INCR8, 1'b1, OKAY);
        apply_stimulus(4'b0101, 4'b0000, SEQ, INCR8, 1'b1, OKAY);
        apply_stimulus(4'b0101, 4'b0000, SEQ, INCR8, 1'b1, OKAY);
        apply_stimulus(4'b0101, 4'b0000, SEQ, INCR8, 1'b0, ERROR);
        apply_stimulus(4'b0101, 4'b0000, SEQ, INCR8, 1'b1, ERROR);
        check_grant("error_hold", 4'b0100);
        apply_stimulus(4'b0001, 4'b0000, IDLE, INCR8, 1'b1, OKAY);
        check_grant("error_regrant", 4'b0001);

        // Master 3 mid-INCR16 (locked) when reset is pulsed asynchronously.
        apply_stimulus(4'b1000, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
        apply_stimulus(4'b1000, 4'b0000, BUSY, INCR16, 1'b1, OKAY);
        apply_stimulus(4'b1000, 4'b1000, NONSEQ, INCR16, 1'b1, OKAY);
        apply_stimulus(4'b1000, 4'b1000, SEQ, INCR16, 1'b1, OKAY);
        check_lock("pre_reset_lock", 1'b1);
        #2 HRST_N = 1'b0;
        #1;
        model_reset();
        check_output("async_reset");
        check_grant("async_grant", 4'b0001);
        check_master("async_master", 3'd0);
        check_lock("async_lock", 1'b0);
        @(posedge HCLK);
        #1;
        check_output("reset_held");
        HRST_N = 1'b1;
        apply_stimulus(4'b1000, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
        check_grant("post_reset_grant", 4'b1000);

        // Randomized traffic checked cycle by cycle against the model.
        for (int n = 0; n < 1500; n++) begin
            logic [NUM-1:0] req;
            logic [NUM-1:0] lck;
            logic [1:0]     resp;
            req  = NUM'($urandom);
            lck  = ($urandom_range(0, 3) == 0) ? (NUM'($urandom) & req) : '0;
            resp = ($urandom_range(0, 7) == 0) ? 2'($urandom) : OKAY;
            apply_stimulus(req, lck, 2'($urandom), 3'($urandom),
                           $urandom_range(0, 4) != 0, resp);
        end

        $display("[TB] random phase done");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- AHB bus arbiter for the debug subsystem.
- Shares one AHB-Lite slave fabric between up to 8 bus masters: the debug-UART AHB master plus DMA/test masters.
- Generates HGRANT and the HMASTER/HMASTLOCK pipeline, which drive the address/data muxes.
- Round-robin priority, burst-boundary-aware handover, locked-transfer hold and a default master.

Parameters:
- NUM_MST, 4, number of masters (2..8).
- DEF_MST, 0, default master index: granted when nobody requests and after reset.

Ports:
- HCLK  in  1  clock.
- HRST_N  in  1  asynchronous active-low reset.
- HBUSREQ  in  NUM_MST  per-master bus request.
- HLOCK  in  NUM_MST  per-master locked-transfer request.
- HTRANS  in  2  muxed transfer type of the current bus owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- HBURST  in  3  muxed burst type of the current bus owner.
- HREADY  in  1  muxed slave ready.
- HRESP  in  2  muxed slave response (OKAY=0, ERROR=1, RETRY=2, SPLIT=3).
- HGRANT  out  NUM_MST  one-hot grant.
- HMASTER  out  3  index of the master owning the address phase.
- HMASTLOCK  out  1  current address phase is locked.

Behaviour:
- Reset (async, HRST_N=0): HGRANT=one-hot(DEF_MST), HMASTER=DEF_MST, HMASTLOCK=0, RR pointer=DEF_MST, beat counter=0, lock flag=0.
- Beat counter, 4 bits, tracks the owner's burst:
  - On HREADY=1 with HTRANS=NONSEQ, load remaining beats: SINGLE=0, INCR4/WRAP4=3, INCR8/WRAP8=7, INCR16/WRAP16=15.
  - Unspecified INCR loads 0 and is treated as interruptible.
  - On HREADY=1 with HTRANS=SEQ, decrement and saturate at 0.
  - BUSY holds the count.
- Arbitration point (ARB) = HREADY=1 AND HMASTLOCK=0 AND HLOCK[grantee]=0 AND any of:
  - HTRANS=IDLE;
  - HTRANS=NONSEQ with HBURST in {SINGLE, INCR};
  - HTRANS=SEQ with counter==1;
  - HBURST=INCR.
- At ARB, next HGRANT is registered (one-cycle latency):
  - Choose the first master with HBUSREQ=1, scanning pointer+1, pointer+2, … modulo NUM_MST. The current grantee is scanned last.
  - If no requests, grant DEF_MST.
  - The pointer updates to the new grantee only when that grantee was actually requesting.
- Outside ARB, HGRANT holds.
- A grantee deasserting HBUSREQ mid-fixed-burst keeps the grant until the burst boundary.
- Handover: when HREADY=1, HMASTER <= index(HGRANT) and HMASTLOCK <= HLOCK[index(HGRANT)]. HMASTER therefore lags HGRANT by at least one cycle and changes only on HREADY.
- Lock:
  - While HLOCK[grantee]=1, the grant is frozen regardless of other requests.
  - The grant stays frozen one further transfer after HLOCK drops, because HMASTLOCK is still 1 until the next HREADY.
- Responses:
  - RETRY or SPLIT, first cycle (HREADY=0): no change.
  - RETRY or SPLIT, second cycle: grant held, counter unchanged. SPLIT is treated as RETRY; no split masking.
  - ERROR, second cycle: counter cleared to 0, so the next HREADY with IDLE/NONSEQ is an ARB.
- Simultaneous requests with pointer=p: the lowest index above p wins, wrapping.
- Only one HGRANT bit is ever high.
- HMASTER is always a valid index < NUM_MST.
- Reset asserted mid-burst returns all outputs to reset values immediately.

Test Plan:
1. Reset, then HBUSREQ=0000, HREADY=1, HTRANS=IDLE -> HGRANT=0001, HMASTER=0, HMASTLOCK=0 held indefinitely.
2. Masters 1 and 3 request together, pointer=0 -> HGRANT=0010 next cycle, HMASTER=1 on the following HREADY. After master 1 completes a SINGLE and goes IDLE -> HGRANT=1000.
3. Master 2 granted, issues INCR4 (NONSEQ, SEQ×3) while master 0 requests; insert HREADY=0 on beat 2 -> HGRANT stays 0100 until SEQ beat 4 is accepted, then becomes 0001 one cycle later.
4. Master 1 asserts HLOCK+HBUSREQ and does two SINGLE transfers while master 3 requests -> HGRANT=0010 throughout, HMASTLOCK=1 on both address phases. After HLOCK drops, one more master-1 transfer, then HGRANT=1000.
5. Master 2 INCR8 hits HRESP=ERROR on beat 3 (two-cycle response), then master 2 drives IDLE with master 0 requesting -> counter cleared, HGRANT=0001 next cycle.
6. Master 3 granted mid-INCR16, HRST_N pulsed low -> HGRANT=0001, HMASTER=0, HMASTLOCK=0 asynchronously; after release, master 3 re-requesting is granted after one cycle.
